smi_mem_fuzz_test_sequencer: RTL
================================

// Module: smi_mem_fuzz_test_sequencer
// PURPOSE
//  Campaign controller for a bank of 64-bit burst fuzz testers sharing one memory.
//  - Accepts one host test configuration and splits the address window into NumLanes equal sub-windows.
//  - Dispatches one config handshake per tester lane, in lane order.
//  - Collects every lane's error-count status and reports an aggregate error count plus a per-lane fail mask.
// PARAMETERS
//  NumLanes   4   number of fuzz tester lanes; power of two, 1..8
//  LaneShift  2   log2(NumLanes); must match NumLanes
//  MinBurst   64  lane sub-window size granularity in bytes
// PORTS
//  clk                  in   1           system clock
//  srst                 in   1           reset, asynchronous, active-low
//  configValid          in   1           host config valid
//  configMemAddrBase    in   64          window base byte address
//  configMemBlockSize   in   32          window size in bytes
//  configNumTests       in   32          tests per lane
//  configStop           out  1           host config stop
//  laneConfigValid      out  NumLanes    per-lane config valid; one-hot or zero
//  laneConfigAddrBase   out  64          shared lane base address
//  laneConfigBlockSize  out  32          shared lane sub-window size
//  laneConfigNumTests   out  32          shared tests per lane
//  laneConfigStop       in   NumLanes    per-lane config stop
//  laneStatusValid      in   NumLanes    per-lane status valid
//  laneStatusErrCount   in   32*NumLanes lane i error count at [32*i+31:32*i]
//  laneStatusStop       out  NumLanes    per-lane status stop
//  statusValid          out  1           aggregate result valid
//  statusErrorCount     out  32          saturating sum of lane error counts
//  statusLaneFailMask   out  NumLanes    bit i set = lane i reported a nonzero count
//  statusStop           in   1           result stop
// BEHAVIOUR
//  - Handshake rule: a transfer occurs on a cycle where valid=1 and stop=0.
//    - A valid, once raised, holds with stable data until the transfer.
//  - Reset (srst=0, async), all outputs:
//    - configStop=1, laneConfigValid=0, laneStatusStop=all 1s
//    - statusValid=0, statusErrorCount=0, statusLaneFailMask=0
//    - FSM returns to IDLE.
//  - Registers:
//    - laneSize = ((configMemBlockSize >> LaneShift) & ~(MinBurst-1)), captured on accept.
//    - Config fields are latched on accept.
//    - laneIdx is 3 bits; pendMask and failMask are NumLanes bits; errSum is 32 bits.
//  - IDLE:
//    - configStop=0.
//    - On accept: errSum=0, failMask=0, pendMask=all 1s, laneIdx=0.
//    - If laneSize!=0 go to DISPATCH, else go to REPORT with errSum=32'hFFFFFFFF and failMask=all 1s.
//  - DISPATCH:
//    - laneConfigValid[laneIdx]=1.
//    - laneConfigAddrBase = base + laneIdx*laneSize (64-bit add, wrap modulo 2^64).
//    - laneConfigBlockSize = laneSize.
//    - On transfer: laneIdx++. After lane NumLanes-1, go to COLLECT.
//    - First laneConfigValid is asserted the cycle after host accept.
//    - configNumTests=0 is still dispatched normally.
//  - COLLECT:
//    - laneStatusStop[i]=0 only for the lowest i with pendMask[i] & laneStatusValid[i]; at most one transfer per cycle.
//    - On transfer from lane i:
//      - errSum = min(errSum + count_i, 32'hFFFFFFFF), using a 33-bit add.
//      - failMask[i] = (count_i != 0).
//      - pendMask[i] = 0.
//    - Go to REPORT when pendMask reaches 0. statusValid rises on the next cycle.
//  - REPORT:
//    - statusValid=1, statusErrorCount=errSum, statusLaneFailMask=failMask.
//    - On transfer go to IDLE. configStop stays 1 until IDLE.
//  - Boundaries:
//    - laneStatusValid outside COLLECT, or from an already-collected lane, is ignored (stop held 1).
//    - Simultaneous lane statuses are serviced lowest index first, one per cycle.
//    - A new host config is never accepted before the report transfer.
//    - Reset mid-campaign drops all state; no partial report is emitted.
// TESTING
//  - Basic run: base=0x1000_0000, size=0x10000, tests=5, lanes stall 0 cycles.
//    -> lane bases 0x1000_0000/0x1000_4000/0x1000_8000/0x1000_C000, blockSize=0x4000.
//    -> status counts 0,0,0,0 give errorCount=0, mask=4'b0000.
//  - Out-of-order status: lanes report in order 3,1,0,2 with counts 2,0,7,0.
//    -> errorCount=9, mask=4'b1001, and statusValid rises exactly 1 cycle after the lane-2 transfer.
//  - Simultaneous status: all 4 lanes valid in the same cycle with counts 1,1,1,1.
//    -> accepted on 4 consecutive cycles in index order 0..3, errorCount=4.
//  - Saturation: counts 0xFFFF_FFF0,0x20,0,0 -> errorCount=0xFFFF_FFFF, mask=4'b0011.
//  - Degenerate size: size=200 with 4 lanes -> laneSize=0, no laneConfigValid pulse, report 0xFFFF_FFFF / 4'b1111.
//  - Stalls and reset: laneConfigStop[1] held high 10 cycles -> lane 2 waits and addr/size stay stable.
//    -> Then assert srst low mid-COLLECT: all outputs return to reset values asynchronously, and the next config runs cleanly.

Source files
------------

// File: rtl/smi_mem_fuzz_test_sequencer.sv
// Campaign controller for a bank of burst fuzz testers sharing one memory.
// Splits a host window across lanes, dispatches configs, aggregates status.
module smi_mem_fuzz_test_sequencer #(
  parameter int unsigned NumLanes  = 4,
  parameter int unsigned LaneShift = 2,
  parameter int unsigned MinBurst  = 64
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     configValid,
  input  logic [63:0]              configMemAddrBase,
  input  logic [31:0]              configMemBlockSize,
  input  logic [31:0]              configNumTests,
  output logic                     configStop,
  output logic [NumLanes-1:0]      laneConfigValid,
  output logic [63:0]              laneConfigAddrBase,
  output logic [31:0]              laneConfigBlockSize,
  output logic [31:0]              laneConfigNumTests,
  input  logic [NumLanes-1:0]      laneConfigStop,
  input  logic [NumLanes-1:0]      laneStatusValid,
  input  logic [32*NumLanes-1:0]   laneStatusErrCount,
  output logic [NumLanes-1:0]      laneStatusStop,
  output logic                     statusValid,
  output logic [31:0]              statusErrorCount,
  output logic [NumLanes-1:0]      statusLaneFailMask,
  input  logic                     statusStop
);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    COLLECT,
    REPORT
  } state_e;

  state_e               state_q, state_d;
  logic [63:0]          base_q, base_d;
  logic [31:0]          size_q, size_d;
  logic [31:0]          tests_q, tests_d;
  logic [2:0]           idx_q, idx_d;
  logic [NumLanes-1:0]  pend_q, pend_d;
  logic [NumLanes-1:0]  fail_q, fail_d;
  logic [31:0]          err_q, err_d;

  logic [31:0]          lane_size_in;
  logic [NumLanes-1:0]  grant;
  logic [31:0]          cnt_sel;
  logic [32:0]          sum;
  logic                 cfg_xfer;
  logic                 lane_xfer;
  logic                 stat_xfer;

  assign lane_size_in = (configMemBlockSize >> LaneShift)
                      & ~(32'(MinBurst - 1));

  // configStop must read 1 while reset is held, even though state is IDLE
  assign configStop = !(srst && (state_q == IDLE));
  assign cfg_xfer   = configValid && !configStop;

  always_comb begin
    laneConfigValid = '0;
    for (int i = 0; i < NumLanes; i++) begin
      laneConfigValid[i] = (state_q == DISPATCH) && (idx_q == 3'(i));
    end
  end

  assign lane_xfer = |(laneConfigValid & ~laneConfigStop);

  assign laneConfigAddrBase  = base_q + 64'(size_q) * 64'(idx_q);
  assign laneConfigBlockSize = size_q;
  assign laneConfigNumTests  = tests_q;

  // Walk downwards so the lowest ready pending lane wins
  always_comb begin
    grant   = '0;
    cnt_sel = '0;
    if (state_q == COLLECT) begin
      for (int i = NumLanes - 1; i >= 0; i--) begin
        if (pend_q[i] && laneStatusValid[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          cnt_sel  = laneStatusErrCount[32*i +: 32];
        end
      end
    end
  end

  assign laneStatusStop = ~grant;
  assign sum            = {1'b0, err_q} + {1'b0, cnt_sel};

  assign statusValid        = (state_q == REPORT);
  assign statusErrorCount   = err_q;
  assign statusLaneFailMask = fail_q;
  assign stat_xfer          = statusValid && !statusStop;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    size_d  = size_q;
    tests_d = tests_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    fail_d  = fail_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_xfer) begin
          base_d  = configMemAddrBase;
          size_d  = lane_size_in;
          tests_d = configNumTests;
          idx_d   = '0;
          pend_d  = '1;
          if (lane_size_in != '0) begin
            err_d   = '0;
            fail_d  = '0;
            state_d = DISPATCH;
          end else begin
            err_d   = '1;
            fail_d  = '1;
            state_d = REPORT;
          end
        end
      end
      DISPATCH: begin
        if (lane_xfer) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'(NumLanes - 1)) begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (|grant) begin
          err_d  = sum[32] ? '1 : sum[31:0];
          fail_d = (fail_q & ~grant)
                 | ((cnt_sel != '0) ? grant : '0);
          pend_d = pend_q & ~grant;
          if ((pend_q & ~grant) == '0) begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (stat_xfer) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state_q <= IDLE;
      base_q  <= '0;
      size_q  <= '0;
      tests_q <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      fail_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      size_q  <= size_d;
      tests_q <= tests_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

endmodule
